alu_exec_ctrl: RTL and testbench

- Multi-cycle execute sequencer that sits between the instruction source and the combinational 16-bit ALU / register file.
- Accepts one instruction at a time over a valid/ready handshake and reads both operands from the register file.
- Drives the ALU opcode, shift amount and operands, captures the result and the S/Z/C/V flags, writes back, then signals completion.
- Owns the architectural flag register and a retired-instruction counter.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_exec_ctrl_if.sv | 9 +
 rtl/alu_flag_reg.sv | 24 ++
 rtl/alu_exec_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, instruction
// field positions, FSM encoding and opcode-class predicates.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_RSV = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  // Instruction word layout; bits [5:4] are reserved and never latched.
  localparam int OP_LO = 12;
  localparam int RD_LO = 9;
  localparam int RS_LO = 6;
  localparam int D_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Arithmetic/logic/shift ops and MOV write the destination register.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op <= OP_XOR) || (op == OP_MOV) || (op >= OP_SLL && op <= OP_SRA);
  endfunction

  // CMP updates flags without writing back; MOV moves data only.
  function automatic logic writes_flags(input logic [3:0] op);
    return (op <= OP_CMP) || (op >= OP_SLL && op <= OP_SRA);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'd12;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake between the instruction source and the sequencer.
interface alu_exec_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_flag_reg.sv
// Architectural {S,Z,C,V} flag register with load enable.
module alu_flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] flags_in,
  output logic [3:0] flags_out
);
  logic [3:0] flags_d, flags_q;

  // Hold unless a flag-writing instruction retires.
  always_comb begin
    flags_d = flags_q;
    if (load) flags_d = flags_in;
  end

  // Flag storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags_out = flags_q;
endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-state execute sequencer: accept instruction, read operands, run the
// combinational ALU, write back and retire. One instruction per 4 cycles.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_ctrl_if.slave    ifc,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_d,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_S,
  input  logic              alu_Z,
  input  logic              alu_C,
  input  logic              alu_V,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_e state_q, state_d;

  // Latched instruction fields; the reserved bits are deliberately dropped.
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [3:0]        dsh_q, dsh_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic flag_load;

  assign accept = (state_q == ST_IDLE) && ifc.instr_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed one-cycle-per-state walk, no stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; instr_ready never looks at instr_valid.
  always_comb begin
    ifc.instr_ready = (state_q == ST_IDLE);
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_WB);
    illegal         = (state_q == ST_WB) && is_illegal(op_q);
    rf_we           = (state_q == ST_WB) && writes_rd(op_q);
    flag_load       = (state_q == ST_WB) && writes_flags(op_q);
  end

  // Datapath next values: latch on accept, operands at end of READ,
  // result/flag candidate at end of EXEC, counter bump at end of WB.
  always_comb begin
    op_d   = op_q;
    rd_d   = rd_q;
    rs_d   = rs_q;
    dsh_d  = dsh_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    wd_d   = wd_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (accept) begin
      op_d  = ifc.instr[OP_LO +: 4];
      rd_d  = ifc.instr[RD_LO +: REG_AW];
      rs_d  = ifc.instr[RS_LO +: REG_AW];
      dsh_d = ifc.instr[D_LO +: 4];
    end
    if (state_q == ST_READ) begin
      opa_d = rf_ra_data;
      opb_d = rf_rb_data;
    end
    if (state_q == ST_EXEC) begin
      wd_d   = alu_out;
      cand_d = {alu_S, alu_Z, alu_C, alu_V};
    end
    if (state_q == ST_WB) cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs_q   <= '0;
      dsh_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      wd_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      rd_q   <= rd_d;
      rs_q   <= rs_d;
      dsh_q  <= dsh_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      wd_q   <= wd_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  alu_flag_reg u_flags (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (flag_load),
    .flags_in (cand_q),
    .flags_out(flags)
  );

  // Fields stay on the ALU/RF buses until the next instruction is latched.
  assign rf_ra_addr  = rd_q;
  assign rf_rb_addr  = rs_q;
  assign rf_wa       = rd_q;
  assign rf_wd       = wd_q;
  assign alu_opcode  = op_q;
  assign alu_d       = dsh_q;
  assign alu_in_a    = opa_q;
  assign alu_in_b    = opb_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl with a behavioural register file and 16-bit ALU.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wa;
  logic [15:0] rf_ra_data, rf_rb_data, rf_wd;
  logic [3:0]  alu_opcode, alu_d, flags;
  logic [15:0] alu_in_a, alu_in_b, alu_out;
  logic        alu_S, alu_Z, alu_C, alu_V;
  logic        rf_we, busy, done, illegal;
  logic [15:0] retired_cnt;

  int checks = 0;
  int failures = 0;

  alu_exec_ctrl_if ifc();

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ifc(ifc),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_opcode(alu_opcode), .alu_d(alu_d),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_out(alu_out),
    .alu_S(alu_S), .alu_Z(alu_Z), .alu_C(alu_C), .alu_V(alu_V),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .flags(flags),
    .busy(busy), .done(done), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write on rising edge; bench preload
  // port takes priority and is only used while the sequencer is idle.
  logic [15:0] regs [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_wa = '0;
  logic [15:0] pre_wd = '0;
  always @(posedge clk) begin
    if (pre_we)     regs[pre_wa] <= pre_wd;
    else if (rf_we) regs[rf_wa]  <= rf_wd;
  end
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  // ALU model: carry is carry-out on ADD, borrow on SUB/CMP, 0 otherwise.
  always_comb begin
    logic [16:0] wide;
    logic [15:0] r;
    logic        c, v;
    wide = '0; r = '0; c = 1'b0; v = 1'b0;
    case (alu_opcode)
      4'd0: begin
        wide = {1'b0, alu_in_a} + {1'b0, alu_in_b};
        r = wide[15:0]; c = wide[16];
        v = (alu_in_a[15] == alu_in_b[15]) && (r[15] != alu_in_a[15]);
      end
      4'd1, 4'd5: begin
        r = alu_in_a - alu_in_b; c = alu_in_a < alu_in_b;
        v = (alu_in_a[15] != alu_in_b[15]) && (r[15] != alu_in_a[15]);
      end
      4'd2:  r = alu_in_a & alu_in_b;
      4'd3:  r = alu_in_a | alu_in_b;
      4'd4:  r = alu_in_a ^ alu_in_b;
      4'd6:  r = alu_in_b;
      4'd8:  r = alu_in_a << alu_d;
      4'd9:  r = alu_in_a >> alu_d;
      4'd10: r = (alu_in_a << alu_d) | (alu_in_a >> (5'd16 - {1'b0, alu_d}));
      4'd11: r = $unsigned($signed(alu_in_a) >>> alu_d);
      default: r = '0;
    endcase
    alu_out = r;
    alu_S = r[15]; alu_Z = (r == 16'h0); alu_C = c; alu_V = v;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pre_a;
    logic [15:0] pre_b;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ill;
    logic [3:0]  flg;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_wa = a; pre_wd = v;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one instruction and check every phase at its fixed cycle.
  task automatic run_vec(input vec_t v);
    logic [3:0] op, d;
    logic [2:0] rd, rs;
    op = v.instr[15:12]; rd = v.instr[11:9]; rs = v.instr[8:6]; d = v.instr[3:0];
    set_reg(rd, v.pre_a);
    set_reg(rs, v.pre_b);
    @(negedge clk);
    chk("ready_idle", ifc.instr_ready, 1);
    ifc.instr_valid = 1'b1; ifc.instr = v.instr;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0; ifc.instr = 16'hDEAD;
    @(negedge clk);
    chk("busy_read", busy, 1);
    chk("ra_addr", rf_ra_addr, rd);
    chk("rb_addr", rf_rb_addr, rs);
    @(negedge clk);
    chk("exec_op", alu_opcode, op);
    chk("exec_d", alu_d, d);
    chk("exec_a", alu_in_a, v.pre_a);
    chk("exec_b", alu_in_b, v.pre_b);
    chk("exec_no_we", rf_we, 0);
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_we", rf_we, v.we);
    chk("wb_illegal", illegal, v.ill);
    chk("wb_d_held", alu_d, d);
    if (v.we) begin
      chk("wb_wa", rf_wa, v.wa);
      chk("wb_wd", rf_wd, v.wd);
    end
    @(negedge clk);
    chk("flags", flags, v.flg);
    chk("retired_cnt", retired_cnt, v.cnt);
    chk("done_pulse", done, 0);
    chk("ready_back", ifc.instr_ready, 1);
    @(negedge clk);
    chk("junk_ignored", busy, 0);
  endtask

  initial begin
    int acc [3];
    int n;
    vec_t post;
    ifc.instr_valid = 1'b0;
    ifc.instr = 16'h0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;

    //          instr     pre_a     pre_b     we wa  wd        ill flags    cnt
    tbl[0] = '{16'h0280, 16'hFFFF, 16'h0001, 1, 1, 16'h0000, 0, 4'b0110, 16'd1}; // ADD r1,r2
    tbl[1] = '{16'h56C0, 16'h0007, 16'h0007, 0, 3, 16'h0000, 0, 4'b0100, 16'd2}; // CMP r3,r3
    tbl[2] = '{16'h6940, 16'h1111, 16'h8000, 1, 4, 16'h8000, 0, 4'b0100, 16'd3}; // MOV r4<-r5
    tbl[3] = '{16'h8C04, 16'h1234, 16'h0000, 1, 6, 16'h2340, 0, 4'b0000, 16'd4}; // SLL r6,4
    tbl[4] = '{16'hE280, 16'h0005, 16'h0003, 0, 1, 16'h0000, 1, 4'b0000, 16'd5}; // illegal 1110
    tbl[5] = '{16'h12B0, 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 0, 4'b0001, 16'd6}; // SUB, rsv bits set
    tbl[6] = '{16'h7280, 16'h0001, 16'h0001, 0, 1, 16'h0000, 0, 4'b0001, 16'd7}; // reserved op 7
    tbl[7] = '{16'hB4CF, 16'h8000, 16'h0000, 1, 2, 16'hFFFF, 0, 4'b1000, 16'd8}; // SRA r2,15

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", rf_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_flags", flags, 0);
    chk("rel_cnt", retired_cnt, 0);
    chk("rel_ready", ifc.instr_ready, 1);
    chk("rel_we", rf_we, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset while an ADD sits in EXEC: abandoned, flags and counter cleared.
    set_reg(3'd1, 16'h0001);
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr = 16'h0280;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_flags", flags, 0);
    chk("mid_rst_cnt", retired_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ill", illegal, 0);
      chk("post_rst_busy", busy, 0);
    end
    post = '{16'h0280, 16'h0001, 16'h0002, 1, 1, 16'h0003, 0, 4'b0000, 16'd1};
    run_vec(post);

    // Back-to-back: valid held high across three XOR r7,r7.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_reg(3'd7, 16'h5A5A);
    n = 0;
    @(negedge clk);
    ifc.instr_valid = 1'b1; ifc.instr = 16'h4FC0;
    for (int i = 0; i < 16 && n < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (ifc.instr_ready) begin
        acc[n] = i;
        n++;
      end
    end
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    chk("b2b_accepts", n, 3);
    if (n == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 4);
      chk("b2b_gap2", acc[2] - acc[1], 4);
    end
    repeat (5) @(negedge clk);
    chk("b2b_cnt", retired_cnt, 3);
    chk("b2b_flags", flags, 4'b0100);
    chk("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
